// File: rtl/inst_fetch_issuer_if.sv
// Handshake bundle between the fetch/issue front end and its neighbours:
// icache request/response, commit-side redirect, issue port toward RS/LSB,
// and queue occupancy. The issuer uses the master view; the environment
// (icache, commit, RS/LSB) uses the slave view.
interface inst_fetch_issuer_if #(
  parameter int QUEUE_ADDR_W = 3
);
  logic                    icache_req_valid;
  logic [31:0]             icache_req_pc;
  logic                    icache_req_ready;
  logic                    icache_resp_valid;
  logic [31:0]             icache_resp_inst;
  logic                    flush_valid;
  logic [31:0]             flush_pc;
  logic                    iss_valid;
  logic                    iss_to_lsb;
  logic [5:0]              iss_inst_type;
  logic [4:0]              iss_rd;
  logic [4:0]              iss_rs1;
  logic [4:0]              iss_rs2;
  logic [31:0]             iss_imm;
  logic [31:0]             iss_pc;
  logic                    rs_ready;
  logic                    lsb_ready;
  logic [QUEUE_ADDR_W:0]   queue_count;

  modport master (
    output icache_req_valid, icache_req_pc,
    input  icache_req_ready, icache_resp_valid, icache_resp_inst,
    input  flush_valid, flush_pc,
    output iss_valid, iss_to_lsb, iss_inst_type, iss_rd, iss_rs1, iss_rs2,
    output iss_imm, iss_pc,
    input  rs_ready, lsb_ready,
    output queue_count
  );

  modport slave (
    input  icache_req_valid, icache_req_pc,
    output icache_req_ready, icache_resp_valid, icache_resp_inst,
    output flush_valid, flush_pc,
    input  iss_valid, iss_to_lsb, iss_inst_type, iss_rd, iss_rs1, iss_rs2,
    input  iss_imm, iss_pc,
    output rs_ready, lsb_ready,
    input  queue_count
  );
endinterface

// File: rtl/inst_fetch_issuer.sv
// Instruction fetch / issue front end.
// Fetches one instruction at a time from the icache into a circular
// instruction queue, decodes the queue head and issues it to the RS or the
// LSB under ready/valid backpressure. A commit-side redirect flushes the
// queue and retargets fetch.
// Optional build macro JAL_PREDICT_EN: when defined, a pushed JAL retargets
// the fetch PC to its jump target; otherwise fetch always advances by 4.
//
// Fetch FSM:
//   state   | meaning
//   IDLE    | no request outstanding; request issued while queue not full
//   WAIT    | request accepted, waiting for the instruction word
//   DROP    | request outstanding but made stale by a flush; discard reply

// RV32I decoder: classifies the major opcode into an instruction type and
// extracts register fields and the raw (unshifted, unextended) immediate.
module decoder (
  input  logic [31:0] inst,
  output logic        legal,
  output logic [5:0]  inst_type,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [20:0] imm
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Type codes: 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 6+f3 branch, 14+f3 load,
  // 22+f3 store, 30+f3 op-imm (38 SRAI), 39+f3 op (47 SUB, 48 SRA), 0 illegal.
  always_comb begin
    legal     = 1'b1;
    inst_type = 6'd0;
    rd        = inst[11:7];
    rs1       = inst[19:15];
    rs2       = inst[24:20];
    imm       = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        inst_type = (opcode == OP_LUI) ? 6'd1 : 6'd2;
        rs1       = '0;
        rs2       = '0;
        imm       = {1'b0, inst[31:12]};
      end
      OP_JAL: begin
        inst_type = 6'd3;
        rs1       = '0;
        rs2       = '0;
        imm       = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        inst_type = 6'd4;
        rs2       = '0;
        imm       = {9'b0, inst[31:20]};
      end
      OP_BRANCH: begin
        inst_type = 6'd6 + {3'b0, funct3};
        rd        = '0;
        imm       = {8'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        inst_type = 6'd14 + {3'b0, funct3};
        rs2       = '0;
        imm       = {9'b0, inst[31:20]};
      end
      OP_STORE: begin
        inst_type = 6'd22 + {3'b0, funct3};
        rd        = '0;
        imm       = {9'b0, inst[31:25], inst[11:7]};
      end
      OP_IMM: begin
        inst_type = (funct3 == 3'd5 && inst[30]) ? 6'd38 : 6'd30 + {3'b0, funct3};
        rs2       = '0;
        imm       = {9'b0, inst[31:20]};
      end
      OP_REG: begin
        if (funct3 == 3'd0 && inst[30])      inst_type = 6'd47;
        else if (funct3 == 3'd5 && inst[30]) inst_type = 6'd48;
        else                                 inst_type = 6'd39 + {3'b0, funct3};
      end
      default: begin
        legal = 1'b0;
        rd    = '0;
        rs1   = '0;
        rs2   = '0;
      end
    endcase
  end
endmodule

module inst_fetch_issuer #(
  parameter int          QUEUE_DEPTH  = 8,
  parameter int          QUEUE_ADDR_W = 3,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  inst_fetch_issuer_if.master     bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [QUEUE_ADDR_W:0] FULL_COUNT = (QUEUE_ADDR_W+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  fetch_state_t             state;
  fetch_state_t             state_next;
  logic [31:0]              pc;
  logic [31:0]              pc_next;
  logic [31:0]              push_target;
  logic                     req_valid;

  logic [31:0]              q_pc   [QUEUE_DEPTH];
  logic [31:0]              q_inst [QUEUE_DEPTH];
  logic [QUEUE_ADDR_W-1:0]  head;
  logic [QUEUE_ADDR_W-1:0]  tail;
  logic [QUEUE_ADDR_W:0]    count;
  logic [QUEUE_ADDR_W:0]    count_next;

  logic                     flush;
  logic                     handshake;
  logic                     push;
  logic                     pop;
  logic                     queue_empty;
  logic                     issue_valid;
  logic                     head_to_lsb;

  logic [31:0]              head_pc;
  logic [31:0]              head_inst;
  logic                     head_legal;
  logic [5:0]               head_type;
  logic [4:0]               head_rd;
  logic [4:0]               head_rs1;
  logic [4:0]               head_rs2;
  logic [20:0]              head_imm;

  assign flush       = rdy_in && bus.flush_valid;
  assign handshake   = req_valid && bus.icache_req_ready;
  // A flush in the same cycle as a response wins: the word is discarded.
  assign push        = (state == ST_WAIT) && bus.icache_resp_valid && !bus.flush_valid;
  assign queue_empty = (count == '0);

  assign head_pc     = q_pc[head];
  assign head_inst   = q_inst[head];
  assign head_to_lsb = (head_inst[6:0] == OP_LOAD) || (head_inst[6:0] == OP_STORE);

  decoder u_decoder (
    .inst      (head_inst),
    .legal     (head_legal),
    .inst_type (head_type),
    .rd        (head_rd),
    .rs1       (head_rs1),
    .rs2       (head_rs2),
    .imm       (head_imm)
  );

  assign issue_valid = !queue_empty && !bus.flush_valid && head_legal;
  // Illegal heads are retired without issue so they cannot block the queue.
  assign pop = (issue_valid && (head_to_lsb ? bus.lsb_ready : bus.rs_ready)) ||
               (!queue_empty && !bus.flush_valid && !head_legal);

`ifdef JAL_PREDICT_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
  logic [20:0] resp_jal_imm;
  assign resp_jal_imm = {bus.icache_resp_inst[31], bus.icache_resp_inst[19:12],
                         bus.icache_resp_inst[20], bus.icache_resp_inst[30:21], 1'b0};
  assign push_target  = (bus.icache_resp_inst[6:0] == OP_JAL) ?
                        pc + {{11{resp_jal_imm[20]}}, resp_jal_imm} : pc + 32'd4;
`else
  assign push_target  = pc + 32'd4;
`endif

  // Next fetch state and PC; DROP still retires on a reply even under a
  // flush, since that reply is the stale request it was waiting for.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_IDLE: if (handshake) state_next = flush ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (bus.icache_resp_valid) state_next = ST_IDLE;
        else if (flush)            state_next = ST_DROP;
      end
      ST_DROP: if (bus.icache_resp_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush)     pc_next = bus.flush_pc;
    else if (push) pc_next = push_target;
  end

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // Fetch FSM with registered request-valid derived from next state/occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_valid <= 1'b0;
    end else if (rdy_in) begin
      state     <= state_next;
      pc        <= pc_next;
      req_valid <= (state_next == ST_IDLE) && (count_next != FULL_COUNT);
    end
  end

  // Queue pointers and occupancy; a flush empties the queue.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      count <= count_next;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
      end
    end
  end

  // Queue storage write; contents need no reset since count gates use.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= bus.icache_resp_inst;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_in) disable iff (rst_in)
    !(rdy_in && push && count == FULL_COUNT));

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_pc    = pc;
  assign bus.iss_valid        = issue_valid;
  assign bus.iss_to_lsb       = head_to_lsb;
  assign bus.iss_inst_type    = head_type;
  assign bus.iss_rd           = head_rd;
  assign bus.iss_rs1          = head_rs1;
  assign bus.iss_rs2          = head_rs2;
  assign bus.iss_imm          = {11'b0, head_imm};
  assign bus.iss_pc           = head_pc;
  assign bus.queue_count      = count;
endmodule

// File: tb/tb_inst_fetch_issuer.sv
// Directed bench for inst_fetch_issuer: a decode vector table pushed through
// fetch and issue, plus hand-written sequences for fill/drain, backpressure,
// freeze, flush and JAL prediction.
module tb_inst_fetch_issuer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  inst_fetch_issuer_if #(.QUEUE_ADDR_W(3)) bus ();

  inst_fetch_issuer #(.QUEUE_DEPTH(8), .QUEUE_ADDR_W(3), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst;
    logic        legal;
    logic        to_lsb;
    logic [5:0]  itype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_vec_t;

  dec_vec_t vecs [10];

  localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] ADDI_X2_10 = 32'h00A00113;
  localparam logic [31:0] LW_X2_8    = 32'h0080A103;
  localparam logic [31:0] JAL_P20    = 32'h0200006F;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_in                 = 1'b1;
    rdy_in                 = 1'b1;
    bus.icache_req_ready   = 1'b0;
    bus.icache_resp_valid  = 1'b0;
    bus.icache_resp_inst   = 32'h0;
    bus.flush_valid        = 1'b0;
    bus.flush_pc           = 32'h0;
    bus.rs_ready           = 1'b0;
    bus.lsb_ready          = 1'b0;
    step();
    rst_in = 1'b0;
  endtask

  // Wait (bounded) for a fetch request, check its PC and accept it.
  task automatic request(input logic [31:0] exp_pc, input string tag);
    bus.icache_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.icache_req_valid) break;
      step();
    end
    check({tag, "_req_valid"}, {31'b0, bus.icache_req_valid}, 32'd1);
    check({tag, "_req_pc"}, bus.icache_req_pc, exp_pc);
    step();
    bus.icache_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] inst);
    bus.icache_resp_valid = 1'b1;
    bus.icache_resp_inst  = inst;
    step();
    bus.icache_resp_valid = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] inst, input logic [31:0] exp_pc, input string tag);
    request(exp_pc, tag);
    respond(inst);
  endtask

  initial begin
    vecs[0] = '{ADDI_X1_5,    1'b1, 1'b0, 6'd30, 5'd1,  5'd0, 5'd0, 32'd5};
    vecs[1] = '{LW_X2_8,      1'b1, 1'b1, 6'd16, 5'd2,  5'd1, 5'd0, 32'd8};
    vecs[2] = '{32'h00312623, 1'b1, 1'b1, 6'd24, 5'd0,  5'd2, 5'd3, 32'd12};
    vecs[3] = '{32'h007302B3, 1'b1, 1'b0, 6'd39, 5'd5,  5'd6, 5'd7, 32'd0};
    vecs[4] = '{32'h407302B3, 1'b1, 1'b0, 6'd47, 5'd5,  5'd6, 5'd7, 32'd0};
    vecs[5] = '{32'h12345537, 1'b1, 1'b0, 6'd1,  5'd10, 5'd0, 5'd0, 32'h12345};
    vecs[6] = '{32'h0000000F, 1'b0, 1'b0, 6'd0,  5'd0,  5'd0, 5'd0, 32'd0};
    vecs[7] = '{32'hFFFFFFFF, 1'b0, 1'b0, 6'd0,  5'd0,  5'd0, 5'd0, 32'd0};
    vecs[8] = '{32'h00208463, 1'b1, 1'b0, 6'd6,  5'd0,  5'd1, 5'd2, 32'd8};
    vecs[9] = '{32'h40225193, 1'b1, 1'b0, 6'd38, 5'd3,  5'd4, 5'd0, 32'h402};

    // Reset state and first fetch/issue latency
    do_reset();
    check("rst_req_valid", {31'b0, bus.icache_req_valid}, 32'd0);
    check("rst_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
    check("rst_count", {28'b0, bus.queue_count}, 32'd0);
    check("rst_req_pc", bus.icache_req_pc, 32'h0);
    bus.rs_ready = 1'b1;
    fetch_one(ADDI_X1_5, 32'h0, "first");
    check("first_iss_valid", {31'b0, bus.iss_valid}, 32'd1);
    check("first_to_lsb", {31'b0, bus.iss_to_lsb}, 32'd0);
    check("first_iss_pc", bus.iss_pc, 32'h0);
    check("first_next_req_valid", {31'b0, bus.icache_req_valid}, 32'd1);
    check("first_next_req_pc", bus.icache_req_pc, 32'h4);
    step();
    check("first_popped_count", {28'b0, bus.queue_count}, 32'd0);
    check("first_popped_iss_valid", {31'b0, bus.iss_valid}, 32'd0);

    // Decode table: each vector fetched, decoded at the head, then popped
    do_reset();
    for (int v = 0; v < 10; v++) begin
      fetch_one(vecs[v].inst, 32'(v * 4), $sformatf("vec%0d", v));
      check($sformatf("vec%0d_iss_valid", v), {31'b0, bus.iss_valid}, {31'b0, vecs[v].legal});
      if (vecs[v].legal) begin
        check($sformatf("vec%0d_to_lsb", v), {31'b0, bus.iss_to_lsb}, {31'b0, vecs[v].to_lsb});
        check($sformatf("vec%0d_type", v), {26'b0, bus.iss_inst_type}, {26'b0, vecs[v].itype});
        check($sformatf("vec%0d_rd", v), {27'b0, bus.iss_rd}, {27'b0, vecs[v].rd});
        check($sformatf("vec%0d_rs1", v), {27'b0, bus.iss_rs1}, {27'b0, vecs[v].rs1});
        check($sformatf("vec%0d_rs2", v), {27'b0, bus.iss_rs2}, {27'b0, vecs[v].rs2});
        check($sformatf("vec%0d_imm", v), bus.iss_imm, vecs[v].imm);
        check($sformatf("vec%0d_pc", v), bus.iss_pc, 32'(v * 4));
        if (vecs[v].to_lsb) bus.lsb_ready = 1'b1;
        else                bus.rs_ready  = 1'b1;
      end
      step();
      check($sformatf("vec%0d_popped", v), {28'b0, bus.queue_count}, 32'd0);
      bus.rs_ready  = 1'b0;
      bus.lsb_ready = 1'b0;
    end

    // Fill to capacity under backpressure, then drain one per cycle
    do_reset();
    for (int i = 0; i < 8; i++) fetch_one(ADDI_X1_5, 32'(i * 4), $sformatf("fill%0d", i));
    check("full_count", {28'b0, bus.queue_count}, 32'd8);
    check("full_req_valid", {31'b0, bus.icache_req_valid}, 32'd0);
    step();
    step();
    check("full_req_valid_held", {31'b0, bus.icache_req_valid}, 32'd0);
    check("full_count_held", {28'b0, bus.queue_count}, 32'd8);
    bus.rs_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_pc", i), bus.iss_pc, 32'(i * 4));
      step();
      check($sformatf("drain%0d_count", i), {28'b0, bus.queue_count}, 32'(7 - i));
      if (i == 0) check("drain_req_resumes", {31'b0, bus.icache_req_valid}, 32'd1);
    end
    bus.rs_ready = 1'b0;
    fetch_one(ADDI_X2_10, 32'h20, "ninth");
    check("ninth_iss_pc", bus.iss_pc, 32'h20);
    check("ninth_count", {28'b0, bus.queue_count}, 32'd1);

    // Load at head blocked by LSB while RS is ready
    do_reset();
    bus.rs_ready = 1'b1;
    fetch_one(LW_X2_8, 32'h0, "lw");
    step();
    step();
    check("lw_blocked_count", {28'b0, bus.queue_count}, 32'd1);
    check("lw_blocked_valid", {31'b0, bus.iss_valid}, 32'd1);
    check("lw_blocked_to_lsb", {31'b0, bus.iss_to_lsb}, 32'd1);
    bus.lsb_ready = 1'b1;
    step();
    check("lw_popped_count", {28'b0, bus.queue_count}, 32'd0);
    bus.lsb_ready = 1'b0;
    bus.rs_ready  = 1'b0;

    // rdy_in low freezes everything, then push and pop land together
    do_reset();
    fetch_one(ADDI_X1_5, 32'h0, "frz_a");
    request(32'h4, "frz_b");
    rdy_in                = 1'b0;
    bus.rs_ready          = 1'b1;
    bus.icache_resp_valid = 1'b1;
    bus.icache_resp_inst  = ADDI_X2_10;
    step();
    step();
    step();
    check("frz_count", {28'b0, bus.queue_count}, 32'd1);
    check("frz_iss_pc", bus.iss_pc, 32'h0);
    check("frz_iss_valid", {31'b0, bus.iss_valid}, 32'd1);
    rdy_in = 1'b1;
    step();
    bus.icache_resp_valid = 1'b0;
    bus.rs_ready          = 1'b0;
    check("pushpop_count", {28'b0, bus.queue_count}, 32'd1);
    check("pushpop_iss_pc", bus.iss_pc, 32'h4);
    check("pushpop_iss_imm", bus.iss_imm, 32'd10);
    check("pushpop_req_pc", bus.icache_req_pc, 32'h8);

    // Flush while WAITing: queue emptied, late response discarded
    do_reset();
    fetch_one(ADDI_X1_5, 32'h0, "fw_a");
    request(32'h4, "fw_b");
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h100;
    #1;
    check("fw_iss_masked", {31'b0, bus.iss_valid}, 32'd0);
    step();
    bus.flush_valid = 1'b0;
    check("fw_count", {28'b0, bus.queue_count}, 32'd0);
    check("fw_drop_req_valid", {31'b0, bus.icache_req_valid}, 32'd0);
    check("fw_req_pc", bus.icache_req_pc, 32'h100);
    respond(ADDI_X2_10);
    check("fw_discard_count", {28'b0, bus.queue_count}, 32'd0);
    check("fw_discard_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
    check("fw_idle_req_valid", {31'b0, bus.icache_req_valid}, 32'd1);
    check("fw_idle_req_pc", bus.icache_req_pc, 32'h100);

    // Flush together with a response and a ready consumer
    do_reset();
    fetch_one(ADDI_X1_5, 32'h0, "fr_a");
    request(32'h4, "fr_b");
    bus.icache_resp_valid = 1'b1;
    bus.icache_resp_inst  = ADDI_X2_10;
    bus.rs_ready          = 1'b1;
    bus.flush_valid       = 1'b1;
    bus.flush_pc          = 32'h200;
    step();
    bus.icache_resp_valid = 1'b0;
    bus.rs_ready          = 1'b0;
    bus.flush_valid       = 1'b0;
    check("fr_count", {28'b0, bus.queue_count}, 32'd0);
    check("fr_req_valid", {31'b0, bus.icache_req_valid}, 32'd1);
    check("fr_req_pc", bus.icache_req_pc, 32'h200);
    check("fr_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
    fetch_one(ADDI_X1_5, 32'h200, "fr_c");
    check("fr_c_iss_pc", bus.iss_pc, 32'h200);

    // Reset in mid-operation with a request outstanding and queue non-empty
    request(32'h204, "mid");
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("mid_rst_req_valid", {31'b0, bus.icache_req_valid}, 32'd0);
    check("mid_rst_count", {28'b0, bus.queue_count}, 32'd0);
    check("mid_rst_iss_valid", {31'b0, bus.iss_valid}, 32'd0);
    check("mid_rst_req_pc", bus.icache_req_pc, 32'h0);

    // JAL at 0x10 with +0x20 offset
    do_reset();
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h10;
    step();
    bus.flush_valid = 1'b0;
    fetch_one(JAL_P20, 32'h10, "jal");
    check("jal_iss_valid", {31'b0, bus.iss_valid}, 32'd1);
    check("jal_type", {26'b0, bus.iss_inst_type}, 32'd3);
    check("jal_imm", bus.iss_imm, 32'h20);
    check("jal_iss_pc", bus.iss_pc, 32'h10);
`ifdef JAL_PREDICT_EN
    check("jal_next_pc", bus.icache_req_pc, 32'h30);
`else
    check("jal_next_pc", bus.icache_req_pc, 32'h14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
